pipe_stage_chain: RTL and testbench

- Parametrised elastic pipeline-register chain; the generalised successor to the fixed IF/ID and ID/EX registers.
- Carries a DATA_W payload and a CTRL_W control bundle through DEPTH stages.
- Per-stage valid bits and bubble collapse; global stall; per-stage flush with control zeroing (bubble insertion).
- Sits between any two pipeline stages of the MIPS datapath, with valid/ready handshake on both sides.

---
 rtl/pipe_stage_chain_if.sv | 14 +
 rtl/pipe_stage_chain.sv | 134 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for one side of the pipe_stage_chain: payload, control and valid/ready.
// A beat transfers in any cycle where valid & ready are both high; ready may depend combinationally on valid-independent state only.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage pipeline register chain with bubble collapse, global stall and per-stage flush.
// Optional PIPE_STATS_EN adds saturating stall_cnt / kill_cnt statistics outputs.
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    pipe_stage_chain_if.slave            up,
    pipe_stage_chain_if.master           dn,
    input  logic                         stall,
    input  logic [DEPTH-1:0]             flush_mask,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  kill_cnt
`endif
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DEPTH-1:0]  occ;
    logic [DEPTH-1:0]  adv;
    logic              in_xfer;

    assign occ = valid_q & ~flush_mask;

    // Walk from the output backwards: a stage may move if the one above is empty or itself moving.
    always_comb begin
        logic carry;
        logic a;
        adv   = '0;
        carry = dn.ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            a      = occ[i] & carry & ~stall;
            adv[i] = a;
            carry  = ~occ[i] | a;
        end
    end

    assign up.ready = rst & ~stall & (~occ[0] | adv[0]);
    assign in_xfer  = up.valid & up.ready;
    assign dn.valid = rst & occ[DEPTH-1] & ~stall;
    assign dn.data  = data_q[DEPTH-1];
    assign dn.ctrl  = dn.valid ? ctrl_q[DEPTH-1] : '0;

    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(occ[i]);
        end
        occupancy = cnt;
    end

    // An incoming entry wins over a flush of the same stage; a flush clears valid and ctrl but keeps data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (in_xfer) begin
            valid_d[0] = 1'b1;
            data_d[0]  = up.data;
            ctrl_d[0]  = up.ctrl;
        end else if (flush_mask[0]) begin
            valid_d[0] = 1'b0;
            ctrl_d[0]  = '0;
        end else if (adv[0]) begin
            valid_d[0] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = data_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
            end else if (flush_mask[i]) begin
                valid_d[i] = 1'b0;
                ctrl_d[i]  = '0;
            end else if (adv[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef PIPE_STATS_EN
    logic [31:0]      stall_cnt_q;
    logic [31:0]      kill_cnt_q;
    logic [OCC_W-1:0] kill_n;
    logic [32:0]      kill_sum;

    always_comb begin
        kill_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_n = kill_n + OCC_W'(valid_q[i] & flush_mask[i]);
        end
        kill_sum = {1'b0, kill_cnt_q} + 33'(kill_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            kill_cnt_q <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus a randomized run against an entry-list model.
module tb_pipe_stage_chain;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int DEPTH  = 3;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stall = 1'b0;
    logic [DEPTH-1:0] flush_mask = '0;
    logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STATS_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      kill_cnt;
`endif

    pipe_stage_chain_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_chain_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    pipe_stage_chain #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (up_if),
        .dn         (dn_if),
        .stall      (stall),
        .flush_mask (flush_mask),
        .occupancy  (occupancy)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .kill_cnt   (kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: live entries oldest-first, each with its stage position.
    logic [DATA_W-1:0] exp_q[$];
    logic [CTRL_W-1:0] exp_ctrl_q[$];
    int                exp_pos_q[$];
    logic [DATA_W-1:0] nxt_q[$];
    logic [CTRL_W-1:0] nxt_ctrl_q[$];
    int                nxt_pos_q[$];
    logic              exp_ir, exp_ov;
    logic [DATA_W-1:0] exp_od;
    logic [CTRL_W-1:0] exp_oc;
    int                exp_occ;

    function automatic void model_clear();
        exp_q.delete();
        exp_ctrl_q.delete();
        exp_pos_q.delete();
    endfunction

    function automatic void model_eval();
        logic [DATA_W-1:0] kd[$];
        logic [CTRL_W-1:0] kc[$];
        int                kp[$];
        int                limit;
        int                np;
        nxt_q.delete();
        nxt_ctrl_q.delete();
        nxt_pos_q.delete();
        for (int k = 0; k < exp_pos_q.size(); k++) begin
            if (!flush_mask[exp_pos_q[k]]) begin
                kd.push_back(exp_q[k]);
                kc.push_back(exp_ctrl_q[k]);
                kp.push_back(exp_pos_q[k]);
            end
        end
        exp_occ = kp.size();
        exp_ov  = !stall && (kp.size() > 0) && (kp[0] == DEPTH - 1);
        exp_od  = exp_ov ? kd[0] : '0;
        exp_oc  = exp_ov ? kc[0] : '0;
        limit   = DEPTH - 1;
        for (int k = 0; k < kp.size(); k++) begin
            if (stall) np = kp[k];
            else if (k == 0 && kp[0] == DEPTH - 1 && dn_if.ready) np = DEPTH;
            else np = (kp[k] + 1 < limit) ? kp[k] + 1 : limit;
            limit = np - 1;
            if (np < DEPTH) begin
                nxt_q.push_back(kd[k]);
                nxt_ctrl_q.push_back(kc[k]);
                nxt_pos_q.push_back(np);
            end
        end
        exp_ir = !stall && !((nxt_pos_q.size() > 0) && (nxt_pos_q[nxt_pos_q.size()-1] == 0));
        if (up_if.valid && exp_ir) begin
            nxt_q.push_back(up_if.data);
            nxt_ctrl_q.push_back(up_if.ctrl);
            nxt_pos_q.push_back(0);
        end
    endfunction

    function automatic void model_commit();
        exp_q      = nxt_q;
        exp_ctrl_q = nxt_ctrl_q;
        exp_pos_q  = nxt_pos_q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        up_if.valid = 1'b0;
        up_if.data  = '0;
        up_if.ctrl  = '0;
        dn_if.ready = 1'b0;
        stall       = 1'b0;
        flush_mask  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        model_clear();
    endtask

    task automatic fill_three(input logic [DATA_W-1:0] base, input logic [CTRL_W-1:0] c0,
                              input logic [CTRL_W-1:0] c1, input logic [CTRL_W-1:0] c2);
        logic [CTRL_W-1:0] cs [3];
        cs[0] = c0; cs[1] = c1; cs[2] = c2;
        dn_if.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            up_if.valid = 1'b1;
            up_if.data  = base + 32'(4 * c);
            up_if.ctrl  = cs[c];
            tick();
        end
        up_if.valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        n_tests += 5;
        if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", dn_if.valid); end
        if (dn_if.data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", dn_if.data); end
        if (dn_if.ctrl !== '0) begin n_fail++; $display("FAIL reset_out_ctrl got %0h want 0", dn_if.ctrl); end
        if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", up_if.ready); end
        tick();
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        n_tests++;
        if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %0b want 1", up_if.ready); end
        tick();
    endtask

    task automatic test_stream();
        do_reset();
        dn_if.ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            up_if.valid = (c < 3);
            up_if.data  = 32'h10 + 32'(4 * c);
            @(negedge clk);
            if (c < 3) begin
                n_tests++;
                if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d got %0b want 1", c, up_if.ready); end
            end
            n_tests++;
            if (dn_if.valid !== (c >= 3 && c < 6)) begin
                n_fail++; $display("FAIL stream_out_valid c=%0d got %0b want %0b", c, dn_if.valid, (c >= 3 && c < 6));
            end
            if (c >= 3 && c < 6) begin
                n_tests++;
                if (dn_if.data !== 32'h10 + 32'(4 * (c - 3))) begin
                    n_fail++; $display("FAIL stream_out_data c=%0d got %0h want %0h", c, dn_if.data, 32'h10 + 32'(4 * (c - 3)));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        dn_if.ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            up_if.valid = 1'b1;
            up_if.data  = 32'h10 + 32'(4 * c);
            @(negedge clk);
            n_tests++;
            if (up_if.ready !== (c < 3)) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %0b want %0b", c, up_if.ready, (c < 3)); end
            if (c == 3) begin
                n_tests++;
                if (occupancy !== OCC_W'(3)) begin n_fail++; $display("FAIL bp_occupancy_full got %0d want 3", occupancy); end
            end
            tick();
        end
        dn_if.ready = 1'b1;
        @(negedge clk);
        n_tests += 3;
        if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %0b want 1", up_if.ready); end
        if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_out_valid got %0b want 1", dn_if.valid); end
        if (dn_if.data !== 32'h10) begin n_fail++; $display("FAIL bp_release_out_data got %0h want 10", dn_if.data); end
        tick();
        up_if.valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests += 2;
            if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid k=%0d got %0b want 1", k, dn_if.valid); end
            if (dn_if.data !== 32'h14 + 32'(4 * k)) begin
                n_fail++; $display("FAIL bp_drain_data k=%0d got %0h want %0h", k, dn_if.data, 32'h14 + 32'(4 * k));
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (occupancy !== '0) begin n_fail++; $display("FAIL bp_drained_occupancy got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_bubble_collapse();
        do_reset();
        dn_if.ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            up_if.valid = (c == 0) || (c == 2);
            up_if.data  = (c == 0) ? 32'h20 : 32'h24;
            dn_if.ready = (c >= 4);
            @(negedge clk);
            if (c == 3 || c == 4) begin
                n_tests += 3;
                if (occupancy !== OCC_W'(2)) begin n_fail++; $display("FAIL bubble_occupancy c=%0d got %0d want 2", c, occupancy); end
                if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL bubble_a_valid c=%0d got %0b want 1", c, dn_if.valid); end
                if (dn_if.data !== 32'h20) begin n_fail++; $display("FAIL bubble_a_data c=%0d got %0h want 20", c, dn_if.data); end
            end
            if (c == 5) begin
                n_tests += 2;
                if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL bubble_b_valid got %0b want 1", dn_if.valid); end
                if (dn_if.data !== 32'h24) begin n_fail++; $display("FAIL bubble_b_data got %0h want 24", dn_if.data); end
            end
            if (c == 6) begin
                n_tests += 2;
                if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL bubble_end_valid got %0b want 0", dn_if.valid); end
                if (occupancy !== '0) begin n_fail++; $display("FAIL bubble_end_occupancy got %0d want 0", occupancy); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        fill_three(32'h30, 8'hFF, 8'hFF, 8'hFF);
        flush_mask = 3'b010;
        @(negedge clk);
        n_tests += 3;
        if (occupancy !== OCC_W'(2)) begin n_fail++; $display("FAIL flush_occupancy got %0d want 2", occupancy); end
        if (dn_if.ctrl !== 8'hFF) begin n_fail++; $display("FAIL flush_top_ctrl got %0h want ff", dn_if.ctrl); end
        if (dn_if.data !== 32'h30) begin n_fail++; $display("FAIL flush_top_data got %0h want 30", dn_if.data); end
        tick();
        flush_mask  = '0;
        dn_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests += 2;
            if (dn_if.valid !== (k < 2)) begin n_fail++; $display("FAIL flush_out_valid k=%0d got %0b want %0b", k, dn_if.valid, (k < 2)); end
            if (dn_if.ctrl !== ((k < 2) ? 8'hFF : 8'h00)) begin
                n_fail++; $display("FAIL flush_out_ctrl k=%0d got %0h want %0h", k, dn_if.ctrl, (k < 2) ? 8'hFF : 8'h00);
            end
            if (k < 2) begin
                n_tests++;
                if (dn_if.data !== ((k == 0) ? 32'h30 : 32'h38)) begin
                    n_fail++; $display("FAIL flush_out_data k=%0d got %0h want %0h", k, dn_if.data, (k == 0) ? 32'h30 : 32'h38);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        fill_three(32'h40, 8'h11, 8'h22, 8'h33);
        stall       = 1'b1;
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        up_if.data  = 32'h4C;
        for (int s = 0; s < 4; s++) begin
            flush_mask = (s == 1) ? 3'b100 : 3'b000;
            @(negedge clk);
            n_tests += 4;
            if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready s=%0d got %0b want 0", s, up_if.ready); end
            if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid s=%0d got %0b want 0", s, dn_if.valid); end
            if (dn_if.ctrl !== 8'h00) begin n_fail++; $display("FAIL stall_out_ctrl s=%0d got %0h want 0", s, dn_if.ctrl); end
            if (occupancy !== OCC_W'((s == 0) ? 3 : 2)) begin
                n_fail++; $display("FAIL stall_occupancy s=%0d got %0d want %0d", s, occupancy, (s == 0) ? 3 : 2);
            end
            tick();
        end
        stall       = 1'b0;
        up_if.valid = 1'b0;
        flush_mask  = '0;
        @(negedge clk);
        n_tests += 2;
        if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL stall_after_valid got %0b want 0", dn_if.valid); end
        if (occupancy !== OCC_W'(2)) begin n_fail++; $display("FAIL stall_after_occupancy got %0d want 2", occupancy); end
`ifdef PIPE_STATS_EN
        n_tests += 2;
        if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL stats_stall_cnt got %0d want 4", stall_cnt); end
        if (kill_cnt !== 32'd1) begin n_fail++; $display("FAIL stats_kill_cnt got %0d want 1", kill_cnt); end
`endif
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests += 2;
            if (dn_if.data !== 32'h44 + 32'(4 * k)) begin
                n_fail++; $display("FAIL stall_drain_data k=%0d got %0h want %0h", k, dn_if.data, 32'h44 + 32'(4 * k));
            end
            if (dn_if.ctrl !== ((k == 0) ? 8'h22 : 8'h33)) begin
                n_fail++; $display("FAIL stall_drain_ctrl k=%0d got %0h want %0h", k, dn_if.ctrl, (k == 0) ? 8'h22 : 8'h33);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_three(32'h50, 8'h01, 8'h02, 8'h03);
        #1;
        n_tests++;
        if (occupancy !== OCC_W'(3)) begin n_fail++; $display("FAIL areset_pre_occupancy got %0d want 3", occupancy); end
        #1 rst = 1'b0;
        #1;
        n_tests += 3;
        if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid got %0b want 0", dn_if.valid); end
        if (occupancy !== '0) begin n_fail++; $display("FAIL areset_occupancy got %0d want 0", occupancy); end
        if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL areset_in_ready got %0b want 0", up_if.ready); end
        tick();
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            up_if.valid = ($urandom_range(0, 3) != 0);
            up_if.data  = $urandom;
            up_if.ctrl  = CTRL_W'($urandom);
            dn_if.ready = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 9) == 0);
            flush_mask  = ($urandom_range(0, 9) == 0) ? DEPTH'($urandom) : '0;
            @(negedge clk);
            model_eval();
            n_tests += 4;
            if (up_if.ready !== exp_ir) begin n_fail++; $display("FAIL rand_in_ready c=%0d got %0b want %0b", c, up_if.ready, exp_ir); end
            if (dn_if.valid !== exp_ov) begin n_fail++; $display("FAIL rand_out_valid c=%0d got %0b want %0b", c, dn_if.valid, exp_ov); end
            if (dn_if.ctrl !== exp_oc) begin n_fail++; $display("FAIL rand_out_ctrl c=%0d got %0h want %0h", c, dn_if.ctrl, exp_oc); end
            if (occupancy !== OCC_W'(exp_occ)) begin n_fail++; $display("FAIL rand_occupancy c=%0d got %0d want %0d", c, occupancy, exp_occ); end
            if (exp_ov) begin
                n_tests++;
                if (dn_if.data !== exp_od) begin n_fail++; $display("FAIL rand_out_data c=%0d got %0h want %0h", c, dn_if.data, exp_od); end
            end
            model_commit();
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
